// File: rtl/filter_bank_switch_pkg.sv
// Shared definitions for the filter bank switch: FSM states, the 1 MHz
// tuning-word constant and the power-on threshold table.
package filter_bank_switch_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEARCH = 3'd1,
    S_DECIDE = 3'd2,
    S_MUTE   = 3'd3,
    S_SETTLE = 3'd4
  } fbs_state_e;

  // Tuning word for 1 MHz (8947848.53 rounded).
  localparam logic [31:0] FREQW_1MHZ = 32'd8947849;

  // Largest threshold table the design supports (N_BANDS up to 16).
  localparam int MAX_THR = 15;

  // Default band edges; entries past the legacy seven sit at full scale.
  function automatic logic [31:0] def_thr(input int idx);
    logic [31:0] v;
    case (idx)
      0:       v = 32'd26843545;
      1:       v = 32'd41160103;
      2:       v = 32'd64424509;
      3:       v = 32'd102005473;
      4:       v = 32'd171798691;
      5:       v = 32'd289910292;
      6:       v = 32'd519869999;
      default: v = 32'hFFFF_FFFF;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/filter_switch_timer.sv
// Loadable down-counter that times the mute intervals around a relay change.
// A load wins over counting; the count rests at zero until reloaded.
module filter_switch_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  // Count down towards zero, restarting from load_val on a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/filter_bank_switch.sv
// Selects the RF filter band for an incoming tuning word. A linear search
// over the programmable threshold table picks a target band, hysteresis
// decides whether to move, and a move is wrapped in a mute / relay change /
// settle sequence.
//
// Handshake: freqw is qualified by the one-cycle strobe freqw_valid; there is
// no backpressure. Words arriving while busy land in a single-depth pending
// slot (newest wins) which is serviced on the first IDLE cycle, unless a fresh
// strobe arrives in that same cycle, in which case the fresh word is taken.
// done pulses for one cycle when a request finishes, with or without a move.
module filter_bank_switch
  import filter_bank_switch_pkg::*;
#(
  parameter int FW         = 32,
  parameter int N_BANDS    = 8,
  parameter int SEL_W      = 3,
  parameter int HYST       = 1048576,
  parameter int MUTE_CYC   = 16,
  parameter int SETTLE_CYC = 64,
  parameter int INVERT     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [FW-1:0]    freqw,
  input  logic             freqw_valid,
  input  logic             thr_we,
  input  logic [SEL_W-1:0] thr_addr,
  input  logic [FW-1:0]    thr_data,
  output logic [SEL_W-1:0] band_id,
  output logic [SEL_W-1:0] filter_select,
  output logic             mute,
  output logic             busy,
  output logic             done,
  output logic [2:0]       fsm_state
);

  localparam int NT       = N_BANDS - 1;
  localparam int CYC_MAX  = (MUTE_CYC > SETTLE_CYC) ? MUTE_CYC : SETTLE_CYC;
  localparam int CNT_W    = $clog2(CYC_MAX + 1);
  localparam logic [FW:0] HYST_W = (FW+1)'(HYST);

  fbs_state_e       state;
  logic [FW-1:0]    thr [NT];
  logic [FW-1:0]    word;
  logic [FW-1:0]    pend_word;
  logic             pend;
  logic [SEL_W-1:0] idx;
  logic [SEL_W-1:0] target;
  logic             found;

  logic [FW-1:0]    thr_idx;
  logic [FW-1:0]    thr_tgt;
  logic [FW-1:0]    thr_tgt_m1;
  logic [FW:0]      up_sum;
  logic [FW:0]      dn_sum;
  logic             do_switch;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic [CNT_W-1:0] tmr_count;
  logic             tmr_zero;

  // Relay wiring may be reversed relative to the band number.
  function automatic logic [SEL_W-1:0] sel_of(input logic [SEL_W-1:0] b);
    return (INVERT != 0) ? (SEL_W'(N_BANDS - 1) - b) : b;
  endfunction

  // Threshold table: reset to defaults, out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NT; i++) thr[i] <= FW'(def_thr(i));
    end else if (thr_we) begin
      for (int i = 0; i < NT; i++) begin
        if (thr_addr == SEL_W'(i)) thr[i] <= thr_data;
      end
    end
  end

  // Threshold read ports for the search index, the target and target-1.
  always_comb begin
    thr_idx    = '0;
    thr_tgt    = '0;
    thr_tgt_m1 = '0;
    for (int i = 0; i < NT; i++) begin
      if (idx == SEL_W'(i))        thr_idx    = thr[i];
      if (target == SEL_W'(i))     thr_tgt    = thr[i];
      if (target == SEL_W'(i + 1)) thr_tgt_m1 = thr[i];
    end
  end

  // Hysteresis test with one extra bit so the sums can never wrap.
  always_comb begin
    up_sum    = {1'b0, thr_tgt_m1} + HYST_W;
    dn_sum    = {1'b0, word} + HYST_W;
    do_switch = 1'b0;
    if (target > band_id)      do_switch = ({1'b0, word} >= up_sum);
    else if (target < band_id) do_switch = (dn_sum < {1'b0, thr_tgt});
  end

  assign tmr_load = ((state == S_DECIDE) && do_switch) ||
                    ((state == S_MUTE) && tmr_zero);
  assign tmr_val  = (state == S_DECIDE) ? CNT_W'(MUTE_CYC - 1)
                                        : CNT_W'(SETTLE_CYC - 1);

  filter_switch_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  // Main sequencer: capture, search, decide, mute, relay change, settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      band_id       <= '0;
      filter_select <= sel_of(SEL_W'(0));
      mute          <= 1'b0;
      done          <= 1'b0;
      pend          <= 1'b0;
      pend_word     <= '0;
      word          <= '0;
      idx           <= '0;
      target        <= '0;
      found         <= 1'b0;
    end else begin
      done <= 1'b0;
      if ((state != S_IDLE) && freqw_valid) begin
        pend      <= 1'b1;
        pend_word <= freqw;
      end
      case (state)
        S_IDLE: begin
          if (freqw_valid || pend) begin
            word   <= freqw_valid ? freqw : pend_word;
            pend   <= 1'b0;
            idx    <= '0;
            found  <= 1'b0;
            target <= SEL_W'(N_BANDS - 1);
            state  <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (!found && (word < thr_idx)) begin
            target <= idx;
            found  <= 1'b1;
          end
          if (idx == SEL_W'(N_BANDS - 2)) state <= S_DECIDE;
          else                            idx   <= idx + SEL_W'(1);
        end
        S_DECIDE: begin
          if (do_switch) begin
            mute  <= 1'b1;
            state <= S_MUTE;
          end else begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_MUTE: begin
          if (tmr_zero) begin
            band_id       <= target;
            filter_select <= sel_of(target);
            state         <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (tmr_zero) begin
            mute  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_filter_bank_switch.sv
// Directed bench for filter_bank_switch with default parameters.
// Cycle k is the clock period after the k-th rising edge, counting the edge
// that samples the freqw_valid strobe as edge 0.
module tb_filter_bank_switch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] freqw;
  logic        freqw_valid;
  logic        thr_we;
  logic [2:0]  thr_addr;
  logic [31:0] thr_data;
  logic [2:0]  band_id;
  logic [2:0]  filter_select;
  logic        mute;
  logic        busy;
  logic        done;
  logic [2:0]  fsm_state;

  int n_assert = 0;
  int n_fail   = 0;

  filter_bank_switch dut (
    .clk           (clk),
    .rst           (rst),
    .freqw         (freqw),
    .freqw_valid   (freqw_valid),
    .thr_we        (thr_we),
    .thr_addr      (thr_addr),
    .thr_data      (thr_data),
    .band_id       (band_id),
    .filter_select (filter_select),
    .mute          (mute),
    .busy          (busy),
    .done          (done),
    .fsm_state     (fsm_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] w);
    freqw       = w;
    freqw_valid = 1'b1;
    step();
    freqw_valid = 1'b0;
  endtask

  task automatic thr_write(input logic [2:0] a, input logic [31:0] d);
    thr_addr = a;
    thr_data = d;
    thr_we   = 1'b1;
    step();
    thr_we   = 1'b0;
  endtask

  // Called right after send(): returns the cycle at which done is seen.
  task automatic wait_done(output int cyc, output logic mute_seen);
    cyc       = 1;
    mute_seen = 1'b0;
    while (done !== 1'b1 && cyc < 300) begin
      if (mute === 1'b1) mute_seen = 1'b1;
      step();
      cyc++;
    end
  endtask

  int   c;
  int   c2;
  logic m;
  int   mute_rise;
  int   sel_chg;
  logic mute_at_chg;
  logic [2:0] band_at_chg;

  initial begin
    rst = 1'b1; freqw = '0; freqw_valid = 1'b0;
    thr_we = 1'b0; thr_addr = '0; thr_data = '0;
    step(); step(); step();

    // Reset state
    chk("rst_band", band_id, 0);
    chk("rst_sel", filter_select, 7);
    chk("rst_mute", mute, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_state", fsm_state, 0);
    rst = 1'b0;

    // 1 MHz word from band 0: stays, done at cycle 9, no mute
    send(32'd8947849);
    chk("lo_busy", busy, 1);
    wait_done(c, m);
    chk("lo_done_cyc", c, 9);
    chk("lo_mute", m, 0);
    chk("lo_band", band_id, 0);
    step();
    chk("lo_done_pulse", done, 0);

    // 10 MHz from band 0 -> band 3, with two strobes during SETTLE
    send(32'd89478485);
    c = 1; mute_rise = -1; sel_chg = -1; mute_at_chg = 1'b0; band_at_chg = '0;
    while (done !== 1'b1 && c < 300) begin
      if (mute === 1'b1 && mute_rise < 0) mute_rise = c;
      if (filter_select !== 3'd7 && sel_chg < 0) begin
        sel_chg     = c;
        mute_at_chg = mute;
        band_at_chg = band_id;
      end
      if (c == 30) begin
        freqw = 32'd8947849; freqw_valid = 1'b1;
      end else if (c == 35) begin
        freqw = 32'd89478485; freqw_valid = 1'b1;
      end else begin
        freqw_valid = 1'b0;
      end
      step();
      c++;
    end
    freqw_valid = 1'b0;
    chk("up_mute_rise", mute_rise, 9);
    chk("up_sel_chg", sel_chg, 25);
    chk("up_mute_at_chg", mute_at_chg, 1);
    chk("up_band_at_chg", band_at_chg, 3);
    chk("up_done_cyc", c, 89);
    chk("up_mute_end", mute, 0);
    chk("up_sel", filter_select, 4);

    // Pending word: only the second strobe (10 MHz, band 3) is serviced
    c2 = c;
    step(); c2++;
    chk("pend_busy", busy, 1);
    chk("pend_done_pulse", done, 0);
    m = 1'b0;
    while (done !== 1'b1 && c2 < 400) begin
      if (mute === 1'b1) m = 1'b1;
      step();
      c2++;
    end
    chk("pend_done_cyc", c2, 98);
    chk("pend_mute", m, 0);
    chk("pend_band", band_id, 3);
    step();

    // Upward hysteresis at band 3
    send(32'd102005473);
    wait_done(c, m);
    chk("h3_stay_cyc", c, 9);
    chk("h3_stay_mute", m, 0);
    chk("h3_stay_band", band_id, 3);
    step();
    send(32'd103054049);
    wait_done(c, m);
    chk("h3_up_cyc", c, 89);
    chk("h3_up_mute", m, 1);
    chk("h3_up_band", band_id, 4);
    chk("h3_up_sel", filter_select, 3);
    step();

    // Downward hysteresis at band 4
    send(32'd101500000);
    wait_done(c, m);
    chk("h4_stay_cyc", c, 9);
    chk("h4_stay_band", band_id, 4);
    step();
    send(32'd100000000);
    wait_done(c, m);
    chk("h4_dn_cyc", c, 89);
    chk("h4_dn_band", band_id, 3);
    chk("h4_dn_sel", filter_select, 4);
    step();

    // Reset in the middle of MUTE aborts the switch
    send(32'd8947849);
    for (int i = 0; i < 11; i++) step();
    chk("ab_mute", mute, 1);
    chk("ab_sel_held", filter_select, 4);
    chk("ab_band_held", band_id, 3);
    rst = 1'b1;
    thr_addr = 3'd7; thr_data = '0; thr_we = 1'b1;
    step();
    chk("ab_mute_clr", mute, 0);
    chk("ab_band", band_id, 0);
    chk("ab_sel", filter_select, 7);
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    rst = 1'b0; thr_we = 1'b0;
    step();

    // Out-of-range threshold write ignored; default table still in force
    thr_write(3'd7, 32'd0);
    send(32'd89478485);
    wait_done(c, m);
    chk("def_cyc", c, 89);
    chk("def_band", band_id, 3);
    chk("def_sel", filter_select, 4);
    step();

    // Programmed threshold moves 10 MHz into band 2
    thr_write(3'd2, 32'd100000000);
    send(32'd89478485);
    wait_done(c, m);
    chk("wr_cyc", c, 89);
    chk("wr_band", band_id, 2);
    chk("wr_sel", filter_select, 5);
    step();

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/filter_bank_switch.md
FILTER_BANK_SWITCH -- requirements
Module: filter_bank_switch

Interface
REQ-001 Parameter FW, default 32, frequency-word width.
REQ-002 Parameter N_BANDS, default 8, number of filter bands (2..16).
REQ-003 Parameter SEL_W, default 3, equals clog2(N_BANDS).
REQ-004 Parameter HYST, default 1048576, hysteresis margin in FREQW LSBs (~0.117 MHz).
REQ-005 Parameter MUTE_CYC, default 16, cycles of mute before the relay change (>=1).
REQ-006 Parameter SETTLE_CYC, default 64, cycles of mute after the relay change (>=1).
REQ-007 Parameter INVERT, default 1; 1 = select is N_BANDS-1-band (legacy relay wiring), 0 = select is band.
REQ-008 Port clk input 1; single clock, all logic on its rising edge.
REQ-009 Port rst input 1; synchronous, active-high reset.
REQ-010 Port freqw input FW; tuning word, 1 MHz = 8947848.53.
REQ-011 Port freqw_valid input 1; one-cycle strobe qualifying freqw.
REQ-012 Port thr_we input 1; threshold write strobe.
REQ-013 Port thr_addr input SEL_W; threshold index 0..N_BANDS-2.
REQ-014 Port thr_data input FW; threshold value.
REQ-015 Port band_id output SEL_W; currently applied band.
REQ-016 Port filter_select output SEL_W; relay drive, mapped per INVERT.
REQ-017 Port mute output 1; high while switching.
REQ-018 Port busy output 1; high in any state other than IDLE.
REQ-019 Port done output 1; one-cycle pulse when a request completes.

Function
REQ-020 Band b covers [thr[b-1], thr[b]); band 0 is below thr[0], band N_BANDS-1 is at or above thr[N_BANDS-2].
REQ-021 FSM states: IDLE, SEARCH, DECIDE, MUTE, SETTLE.
REQ-022 IDLE: on freqw_valid (or a held pending word), capture the word and go to SEARCH.
REQ-023 SEARCH: compare one threshold per cycle, index 0 upward, for N_BANDS-1 cycles; target = first i with word < thr[i], else N_BANDS-1; then go to DECIDE.
REQ-024 DECIDE, upward (target > band_id): switch only if word >= thr[target-1] + HYST, else keep band_id.
REQ-025 DECIDE, downward (target < band_id): switch only if word + HYST < thr[target], else keep band_id.
REQ-026 Hysteresis sums are computed at FW+1 bits; no wrap-around.
REQ-027 DECIDE with no switch: return to IDLE and pulse done in the following cycle; mute stays 0.
REQ-028 DECIDE with a switch: go to MUTE; mute=1 and the old select are held for MUTE_CYC cycles.
REQ-029 On leaving MUTE, band_id and filter_select update to the target and SETTLE is entered; it holds mute=1 for SETTLE_CYC cycles.
REQ-030 On leaving SETTLE: go to IDLE, mute=0 and done=1 in the same cycle.
REQ-031 freqw_valid while busy is stored in a single-depth pending register; a newer word overwrites it; it is serviced on the first IDLE cycle.
REQ-032 freqw_valid in the same cycle as the pending word is serviced: freqw wins and the pending flag clears.
REQ-033 Threshold writes apply on the next cycle, in any state; thr_addr >= N_BANDS-1 is ignored.
REQ-034 Threshold monotonicity is software's responsibility; non-monotonic tables still follow REQ-023 literally.
REQ-035 filter_select and band_id are registered and change only at the MUTE->SETTLE transition.

Reset
REQ-036 Reset gives: state IDLE, band_id=0, filter_select=N_BANDS-1 (INVERT=1) or 0 (INVERT=0), mute=0, busy=0, done=0, pending cleared, counters 0.
REQ-037 Thresholds reset to the package defaults 26843545, 41160103, 64424509, 102005473, 171798691, 289910292, 519869999.
REQ-038 Reset during MUTE or SETTLE aborts the switch immediately; no partial band is applied.

Structure
REQ-039 A shared package holds the state enum, the default threshold table and the 1 MHz FREQW constant.
REQ-040 One sub-module, filter_switch_timer, provides the loadable down-counter used for MUTE and SETTLE.

Verification
REQ-041 After reset, freqw=8947849 at cycle 0 -> band_id=0, mute never set, done at cycle N_BANDS+1 (9).
REQ-042 freqw=89478485 (10 MHz) from band 0 -> mute rises at cycle 9; filter_select 7->4 after 16 more cycles; mute falls and done pulses 64 cycles later.
REQ-043 At band 3: freqw=102005473 -> stays band 3; freqw=103054049 -> switches to band 4.
REQ-044 At band 4: freqw=101500000 -> stays band 4; freqw=100000000 -> band 3.
REQ-045 Two freqw_valid strobes during SETTLE -> only the second word is processed after the first done.
REQ-046 rst asserted mid-MUTE -> next cycle mute=0, band_id=0, filter_select=7; a thr_addr=7 write is ignored.
